// File: rtl/mha_pkg.sv
// rtl/mha_pkg.sv - shared state type and defaults for the systolic-array skew feeder
package mha_pkg;

  localparam int D_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - triangular delay line: lane i is delayed by i shift strobes
module sa_skew_line #(
  parameter int LANES = 16,
  parameter int D_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_ni,
  input  logic                 shift_i,
  input  logic [LANES*D_W-1:0] data_i,
  output logic [LANES*D_W-1:0] data_o
);

  assign data_o[0 +: D_W] = data_i[0 +: D_W];

  for (genvar i = 1; i < LANES; i++) begin : g_lane
    logic [D_W-1:0] tap_q [i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < i; k++) tap_q[k] <= '0;
      end else if (!clr_ni) begin
        for (int k = 0; k < i; k++) tap_q[k] <= '0;
      end else if (shift_i) begin
        tap_q[0] <= data_i[i*D_W +: D_W];
        for (int k = 1; k < i; k++) tap_q[k] <= tap_q[k-1];
      end
    end

    assign data_o[i*D_W +: D_W] = tap_q[i-1];
  end

endmodule

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - tile sequencer feeding skewed X/W wavefronts into a systolic array
module sa_skew_feeder
  import mha_pkg::*;
#(
  parameter int D_W    = D_W_DEF,
  parameter int SA_R   = 16,
  parameter int SA_C   = 16,
  parameter int K_W    = 8,
  parameter int W_SKEW = 1
) (
  input  logic                I_CLK,
  input  logic                I_ASYN_RSTN,
  input  logic                I_SYNC_RSTN,
  input  logic                I_START,
  input  logic [K_W-1:0]      I_K_LEN,
  input  logic                I_VLD,
  output logic                O_RDY,
  input  logic [SA_R*D_W-1:0] I_X,
  input  logic [SA_C*D_W-1:0] I_W,
  input  logic                I_SHIFT,
  output logic [SA_R*D_W-1:0] O_X,
  output logic [SA_C*D_W-1:0] O_W,
  output logic                O_SA_START,
  output logic                O_SA_END,
  output logic                O_DONE,
  output logic                O_BUSY
);

  // Zeros must travel the full diagonal so the last beat reaches the far PE.
  localparam int              FL      = SA_R + SA_C - 2;
  localparam int              FC_W    = $clog2(SA_R + SA_C);
  localparam logic [FC_W-1:0] FL_LAST = FC_W'((FL > 0) ? FL - 1 : 0);
  localparam logic [FC_W-1:0] F_ONE   = FC_W'(1);
  localparam logic [K_W-1:0]  K_ONE   = K_W'(1);

  feed_state_e     state_q, state_d;
  logic [K_W-1:0]  k_len_q, k_len_d;
  logic [K_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;

  logic                rdy;
  logic                accept;
  logic                sa_start;
  logic                sa_end;
  logic [SA_R*D_W-1:0] x_gated;
  logic [SA_C*D_W-1:0] w_gated;

  assign rdy     = (state_q == ST_FEED) && I_SHIFT;
  assign accept  = rdy && I_VLD;
  assign x_gated = accept ? I_X : '0;
  assign w_gated = accept ? I_W : '0;

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else if (!I_SYNC_RSTN) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    sa_start    = 1'b0;
    sa_end      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_START && (I_K_LEN != '0)) begin
          k_len_d     = I_K_LEN;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = ST_FEED;
        end
      end
      ST_FEED: begin
        if (accept) begin
          sa_start   = (beat_cnt_q == '0);
          beat_cnt_d = beat_cnt_q + K_ONE;
          if (beat_cnt_d == k_len_q) begin
            if (FL == 0) begin
              sa_end  = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (I_SHIFT) begin
          flush_cnt_d = flush_cnt_q + F_ONE;
          if (flush_cnt_q == FL_LAST) begin
            sa_end  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign O_RDY      = rdy;
  assign O_SA_START = sa_start;
  assign O_SA_END   = sa_end;
  assign O_DONE     = (state_q == ST_DONE);
  assign O_BUSY     = (state_q != ST_IDLE);

  sa_skew_line #(.LANES(SA_R), .D_W(D_W)) u_x_line (
    .clk_i  (I_CLK),
    .rst_ni (I_ASYN_RSTN),
    .clr_ni (I_SYNC_RSTN),
    .shift_i(I_SHIFT),
    .data_i (x_gated),
    .data_o (O_X)
  );

  if (W_SKEW != 0) begin : g_w_skew
    sa_skew_line #(.LANES(SA_C), .D_W(D_W)) u_w_line (
      .clk_i  (I_CLK),
      .rst_ni (I_ASYN_RSTN),
      .clr_ni (I_SYNC_RSTN),
      .shift_i(I_SHIFT),
      .data_i (w_gated),
      .data_o (O_W)
    );
  end else begin : g_w_flat
    // Weight-stationary preload: weights go straight in, no diagonal.
    assign O_W = w_gated;
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb/tb_sa_skew_feeder.sv - self-checking bench for sa_skew_feeder with a strobe-history model
module tb_sa_skew_feeder;

  localparam int D_W  = 16;
  localparam int SA_R = 4;
  localparam int SA_C = 4;
  localparam int K_W  = 8;
  localparam int FL   = SA_R + SA_C - 2;

  logic                clk = 1'b0;
  logic                asyn_rstn, sync_rstn, start, vld, shift;
  logic [K_W-1:0]      k_len;
  logic [SA_R*D_W-1:0] x;
  logic [SA_C*D_W-1:0] w;

  logic                rdy, sa_st, sa_end, done, busy;
  logic [SA_R*D_W-1:0] ox;
  logic [SA_C*D_W-1:0] ow;
  logic                rdy_n, sa_st_n, sa_end_n, done_n, busy_n;
  logic [SA_R*D_W-1:0] ox_n;
  logic [SA_C*D_W-1:0] ow_n;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  sa_skew_feeder #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_W(K_W), .W_SKEW(1)) u_dut (
    .I_CLK(clk), .I_ASYN_RSTN(asyn_rstn), .I_SYNC_RSTN(sync_rstn), .I_START(start),
    .I_K_LEN(k_len), .I_VLD(vld), .O_RDY(rdy), .I_X(x), .I_W(w), .I_SHIFT(shift),
    .O_X(ox), .O_W(ow), .O_SA_START(sa_st), .O_SA_END(sa_end), .O_DONE(done), .O_BUSY(busy)
  );

  sa_skew_feeder #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_W(K_W), .W_SKEW(0)) u_dut_ns (
    .I_CLK(clk), .I_ASYN_RSTN(asyn_rstn), .I_SYNC_RSTN(sync_rstn), .I_START(start),
    .I_K_LEN(k_len), .I_VLD(vld), .O_RDY(rdy_n), .I_X(x), .I_W(w), .I_SHIFT(shift),
    .O_X(ox_n), .O_W(ow_n), .O_SA_START(sa_st_n), .O_SA_END(sa_end_n), .O_DONE(done_n), .O_BUSY(busy_n)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 feed, 2 flush, 3 done; history holds gated beats per strobe.
  int                  m_ph, m_klen, m_acc, m_fl;
  logic [SA_R*D_W-1:0] hx[$];
  logic [SA_C*D_W-1:0] hw[$];

  task automatic model_reset();
    m_ph = 0; m_klen = 0; m_acc = 0; m_fl = 0;
    hx.delete();
    hw.delete();
  endtask

  function automatic logic [SA_R*D_W-1:0] expect_x(input logic [SA_R*D_W-1:0] cur);
    logic [SA_R*D_W-1:0] r, e;
    int idx;
    r = '0;
    r[0 +: D_W] = cur[0 +: D_W];
    for (int i = 1; i < SA_R; i++) begin
      idx = hx.size() - i;
      if (idx >= 0) begin
        e = hx[idx];
        r[i*D_W +: D_W] = e[i*D_W +: D_W];
      end
    end
    return r;
  endfunction

  function automatic logic [SA_C*D_W-1:0] expect_w(input logic [SA_C*D_W-1:0] cur);
    logic [SA_C*D_W-1:0] r, e;
    int idx;
    r = '0;
    r[0 +: D_W] = cur[0 +: D_W];
    for (int j = 1; j < SA_C; j++) begin
      idx = hw.size() - j;
      if (idx >= 0) begin
        e = hw[idx];
        r[j*D_W +: D_W] = e[j*D_W +: D_W];
      end
    end
    return r;
  endfunction

  logic                e_busy, e_rdy, e_acc, e_st, e_end, e_done;
  logic [SA_R*D_W-1:0] gx, ex;
  logic [SA_C*D_W-1:0] gw, ew;

  initial model_reset();

  always @(negedge clk) begin
    if (!asyn_rstn) model_reset();
    e_busy = (m_ph != 0);
    e_rdy  = (m_ph == 1) && shift;
    e_acc  = e_rdy && vld;
    e_st   = e_acc && (m_acc == 0);
    e_end  = ((m_ph == 1) && e_acc && (m_acc + 1 == m_klen) && (FL == 0)) ||
             ((m_ph == 2) && shift && (m_fl + 1 == FL));
    e_done = (m_ph == 3);
    gx = e_acc ? x : '0;
    gw = e_acc ? w : '0;
    ex = expect_x(gx);
    ew = expect_w(gw);
    check("busy", busy, e_busy);
    check("rdy", rdy, e_rdy);
    check("sa_start", sa_st, e_st);
    check("sa_end", sa_end, e_end);
    check("done", done, e_done);
    check("o_x", ox, ex);
    check("o_w", ow, ew);
    check("ns_busy", busy_n, e_busy);
    check("ns_done", done_n, e_done);
    check("ns_sa_end", sa_end_n, e_end);
    check("ns_o_x", ox_n, ex);
    check("ns_o_w", ow_n, gw);
    if (asyn_rstn) begin
      if (!sync_rstn) model_reset();
      else begin
        if (shift) begin
          hx.push_back(gx);
          hw.push_back(gw);
          while (hx.size() > SA_R) hx.delete(0);
          while (hw.size() > SA_C) hw.delete(0);
        end
        case (m_ph)
          0: if (start && (k_len != 0)) begin
               m_ph = 1; m_klen = int'(k_len); m_acc = 0; m_fl = 0;
             end
          1: if (e_acc) begin
               m_acc++;
               if (m_acc == m_klen) m_ph = (FL == 0) ? 3 : 2;
             end
          2: if (shift) begin
               m_fl++;
               if (m_fl == FL) m_ph = 3;
             end
          default: m_ph = 0;
        endcase
      end
    end
  end

  logic [D_W-1:0] rec_x0[16], rec_x2[16], rec_w3[16], rec_w3n[16];
  logic           rec_st[16], rec_end[16], rec_done[16], rec_busy[16];

  // Beat at strobe s carries value s+1 on every lane; vpat[s] is I_VLD at strobe s.
  task automatic run_tile(input int klen, input logic [15:0] vpat, input int ncyc);
    logic [D_W-1:0] v;
    @(posedge clk); #1;
    start = 1'b1; k_len = K_W'(klen); shift = 1'b1; vld = 1'b0; x = '0; w = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < ncyc; s++) begin
      v = D_W'(s + 1);
      vld = vpat[s];
      x = {SA_R{v}};
      w = {SA_C{v}};
      @(negedge clk);
      rec_x0[s]  = ox[0 +: D_W];
      rec_x2[s]  = ox[2*D_W +: D_W];
      rec_w3[s]  = ow[3*D_W +: D_W];
      rec_w3n[s] = ow_n[3*D_W +: D_W];
      rec_st[s]  = sa_st;
      rec_end[s] = sa_end;
      rec_done[s] = done;
      rec_busy[s] = busy;
      @(posedge clk); #1;
    end
    vld = 1'b0; x = '0; w = '0;
  endtask

  int done_seen;

  initial begin
    asyn_rstn = 1'b0; sync_rstn = 1'b1; start = 1'b0; k_len = '0;
    vld = 1'b0; shift = 1'b0; x = '0; w = '0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_o_x", ox, '0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1;
    asyn_rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Contiguous tile of three beats.
    run_tile(3, 16'hFFFF, 11);
    check("t1_lane0_s0", rec_x0[0], 16'd1);
    check("t1_lane2_s2", rec_x2[2], 16'd1);
    check("t1_lane2_s3", rec_x2[3], 16'd2);
    check("t1_lane2_s4", rec_x2[4], 16'd3);
    check("t1_w3_s3", rec_w3[3], 16'd1);
    check("t1_start_s0", rec_st[0], 1'b1);
    check("t1_end_s7", rec_end[7], 1'b0);
    check("t1_end_s8", rec_end[8], 1'b1);
    check("t1_done_s8", rec_done[8], 1'b0);
    check("t1_done_s9", rec_done[9], 1'b1);
    check("t1_busy_s10", rec_busy[10], 1'b0);
    check("t1_ns_w3_s1", rec_w3n[1], 16'd2);
    check("t1_ns_w3_s5", rec_w3n[5], 16'd0);

    // Bubble at strobe 1: accepted beats carry 1, 3, 4.
    run_tile(3, 16'hFFFD, 12);
    check("t2_lane0_s1", rec_x0[1], 16'd0);
    check("t2_lane2_s2", rec_x2[2], 16'd1);
    check("t2_lane2_s3", rec_x2[3], 16'd0);
    check("t2_lane2_s4", rec_x2[4], 16'd3);
    check("t2_lane2_s5", rec_x2[5], 16'd4);
    check("t2_end_s9", rec_end[9], 1'b1);
    check("t2_done_s10", rec_done[10], 1'b1);
    check("t2_busy_s11", rec_busy[11], 1'b0);

    // Shift stall mid-feed.
    start = 1'b1; k_len = 8'd4; shift = 1'b1; vld = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; vld = 1'b1; x = {SA_R{16'd7}}; w = {SA_C{16'd7}};
    @(posedge clk); #1;
    shift = 1'b0; x = {SA_R{16'd9}};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_rdy", rdy, 1'b0);
      check("stall_lane0", ox[0 +: D_W], 16'd0);
      check("stall_lane1", ox[D_W +: D_W], 16'd7);
      check("stall_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    shift = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vld = 1'b0;

    // Synchronous clear during flush abandons the tile.
    start = 1'b1; k_len = 8'd1; shift = 1'b1; vld = 1'b1; x = {SA_R{16'h55}}; w = {SA_C{16'h66}};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sync_rstn = 1'b0;
    @(posedge clk); #1;
    sync_rstn = 1'b1;
    @(negedge clk);
    check("sclr_busy", busy, 1'b0);
    check("sclr_o_x", ox, '0);
    check("sclr_o_w", ow, '0);
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("sclr_no_done", done_seen, 0);
    @(posedge clk); #1;

    // Zero-length start is ignored.
    start = 1'b1; k_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("klen0_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset mid-feed takes effect without a clock edge.
    start = 1'b1; k_len = 8'd5; vld = 1'b1; shift = 1'b1; x = {SA_R{16'h11}};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    asyn_rstn = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_o_x", ox, '0);
    check("arst_rdy", rdy, 1'b0);
    @(posedge clk); #1;
    asyn_rstn = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 7) == 0);
      k_len     = K_W'($urandom_range(0, 12));
      vld       = ($urandom_range(0, 3) != 0);
      shift     = ($urandom_range(0, 3) != 0);
      x         = {$urandom, $urandom};
      w         = {$urandom, $urandom};
      sync_rstn = ($urandom_range(0, 199) != 0);
      asyn_rstn = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    asyn_rstn = 1'b1; sync_rstn = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
